seq_booth_mult: RTL

- Parametrised sequential multiplier; successor to the team's fixed 8x8 combinational signed array multiplier.
- Uses radix-2 Booth recoding, one partial-product step per clock. This trades latency for area.
- Runtime mode selects signed (two's complement) or unsigned operands.
- Sits behind a simple start/done handshake and is used wherever a full-width combinational array is too large.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/seq_booth_mult_step.sv | 26 ++
 rtl/seq_booth_mult.sv | 85 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential radix-2 Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth steps per product: one per bit of the extended operand
  function automatic int n_iter(input int w);
    return w + 1;
  endfunction

  function automatic int ext_w(input int w);
    return w + 1;
  endfunction

  // accumulator : extended multiplier : appended Booth bit
  function automatic int p_w(input int w);
    return 2 * (w + 1) + 1;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/seq_booth_mult_step.sv
// One radix-2 Booth step: conditional add/subtract of the multiplicand into the
// accumulator, then arithmetic right shift of the whole P register.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]       i_acc,
  input  logic [WIDTH:0]       i_a_ext,
  input  logic [WIDTH+1:0]     i_low,
  output logic [2*WIDTH+2:0]   o_p
);

  logic [WIDTH:0] w_sum;

  // i_low[1:0] is the Booth pair {multiplier LSB, appended bit}
  always_comb begin
    w_sum = i_acc;
    unique case (i_low[1:0])
      2'b01:   w_sum = i_acc + i_a_ext;
      2'b10:   w_sum = i_acc - i_a_ext;
      default: w_sum = i_acc;
    endcase
  end

  assign o_p = {w_sum[WIDTH], w_sum, i_low[WIDTH+1:1]};

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential signed/unsigned multiplier, one radix-2 Booth step per clock,
// behind a start/busy/done handshake.
module seq_booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = n_iter(WIDTH);
  localparam int EW = ext_w(WIDTH);
  localparam int PW = p_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_p, w_p_step;
  logic [EW-1:0]      r_a_ext;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic [EW-1:0]      w_a_ext, w_b_ext;
  logic               w_accept, w_last;

  // Extending by one bit lets the same signed datapath cover unsigned operands
  assign w_a_ext  = {signed_mode & a[WIDTH-1], a};
  assign w_b_ext  = {signed_mode & b[WIDTH-1], b};
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_p[PW-1 -: EW]),
    .i_a_ext (r_a_ext),
    .i_low   (r_p[EW:0]),
    .o_p     (w_p_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p       <= '0;
      r_a_ext   <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a_ext <= w_a_ext;
      r_p     <= {{EW{1'b0}}, w_b_ext, 1'b0};
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_p   <= w_p_step;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_product <= w_p_step[2*WIDTH:1];
    end
  end

  assign product = r_product;

endmodule
